// File: rtl/aes_round_key_store_256.sv
// Round-key buffer for AES-256: captures rk0 plus the 14 expander subkeys, serves them by round number.
// Latency: read data one cycle after an accepted rd_en; keys_ready one cycle after subkey 14 is written.
// Backpressure: none; reads outside READY or with rd_round > 14 are dropped and rd_key holds its value.
module aes_round_key_store_256 #(
    parameter int KEY_W  = 128,
    parameter int NUM_RK = 15,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_start,
    input  logic [KEY_W-1:0] rk0_in,
    input  logic [KEY_W-1:0] skey,
    input  logic [IDX_W-1:0] skey_idx,
    input  logic             skey_valid,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_round,
    input  logic             rd_dec,
    output logic [KEY_W-1:0] rd_key,
    output logic             rd_valid,
    output logic             keys_ready,
    output logic             load_err
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RK - 1);

    state_t           state;
    logic [IDX_W-1:0] exp_idx;
    logic [KEY_W-1:0] entry [NUM_RK];

    logic             skey_hit;
    logic             skey_bad;
    logic             rd_accept;
    logic [IDX_W-1:0] rd_phys;
    logic [KEY_W-1:0] rd_sel;

    // Range of skey_idx is covered by the equality test: exp_idx only ever holds 1..14 while loading.
    assign skey_hit  = (state == LOADING) && skey_valid && (skey_idx == exp_idx);
    assign skey_bad  = (state == LOADING) && skey_valid && (skey_idx != exp_idx);
    assign rd_accept = rd_en && (state == READY) && (rd_round <= LAST_IDX);
    assign rd_phys   = rd_dec ? (LAST_IDX - rd_round) : rd_round;
    // Entry 0 is write-first so a read racing a reload sees the new round-0 key.
    assign rd_sel    = (load_start && (rd_phys == '0)) ? rk0_in : entry[rd_phys];

    always_ff @(posedge clk) begin
        if (load_start) begin
            entry[0] <= rk0_in;
        end else if (skey_hit) begin
            entry[skey_idx] <= skey;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            exp_idx    <= IDX_W'(1);
            rd_key     <= '0;
            rd_valid   <= 1'b0;
            keys_ready <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_key <= rd_sel;
            end

            if (load_start) begin
                state      <= LOADING;
                exp_idx    <= IDX_W'(1);
                load_err   <= 1'b0;
                keys_ready <= 1'b0;
            end else begin
                case (state)
                    LOADING: begin
                        if (skey_hit) begin
                            if (exp_idx == LAST_IDX) begin
                                state      <= READY;
                                keys_ready <= 1'b1;
                            end else begin
                                exp_idx <= exp_idx + IDX_W'(1);
                            end
                        end else if (skey_bad) begin
                            load_err <= 1'b1;
                            state    <= EMPTY;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_round_key_store_256.sv
// Bench for aes_round_key_store_256: subkeys come from a full AES-256 key expansion model,
// reads are checked against an array of the last completed key set.
module tb_aes_round_key_store_256;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load_start;
    logic [127:0] rk0_in;
    logic [127:0] skey;
    logic [3:0]   skey_idx;
    logic         skey_valid;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic         rd_dec;
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         keys_ready;
    logic         load_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox     [256];
    logic [127:0] exp_rk   [15];
    logic [127:0] model_rk [15];
    logic [127:0] last_key;

    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes_round_key_store_256 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_start (load_start),
        .rk0_in     (rk0_in),
        .skey       (skey),
        .skey_idx   (skey_idx),
        .skey_valid (skey_valid),
        .rd_en      (rd_en),
        .rd_round   (rd_round),
        .rd_dec     (rd_dec),
        .rd_key     (rd_key),
        .rd_valid   (rd_valid),
        .keys_ready (keys_ready),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] e;
        e = 8'd254;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int b = 7; b >= 0; b--) begin
                inv = gmul(inv, inv);
                if (e[b]) inv = gmul(inv, 8'(x));
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                t = subword(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    function automatic int phys(input int r, input bit dec);
        return dec ? 14 - r : r;
    endfunction

    // Drive helpers: entered and left at a falling edge.
    task automatic start_load(input logic [255:0] key);
        expand_key(key);
        load_start = 1'b1;
        rk0_in     = exp_rk[0];
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic feed(input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            skey_valid = 1'b1;
            skey_idx   = 4'(i);
            skey       = exp_rk[i];
            @(negedge clk);
            skey_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic commit_model();
        for (int r = 0; r < 15; r++) model_rk[r] = exp_rk[r];
    endtask

    task automatic issue_read(input int r, input bit dec);
        rd_en    = 1'b1;
        rd_round = 4'(r);
        rd_dec   = dec;
        @(negedge clk);
        rd_en    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_start = 1'b0; rk0_in = '0; skey = '0; skey_idx = '0;
        skey_valid = 1'b0; rd_en = 1'b0; rd_round = '0; rd_dec = 1'b0;
        last_key = '0;
        repeat (2) @(negedge clk);
        if ({rd_valid, keys_ready, load_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {rd_valid, keys_ready, load_err});
        end
        checks++;
        if (rd_key !== 128'h0) begin
            errors++; $display("FAIL reset_rd_key got %h want 0", rd_key);
        end
        checks++;
        reset_n = 1'b1;
        @(negedge clk);
        issue_read(0, 1'b0);
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL empty_read got rd_valid %b want 0", rd_valid);
        end
        checks++;
    endtask

    task automatic test_normal_load();
        start_load(FIPS_KEY);
        feed(1, 13, 0);
        skey_valid = 1'b1; skey_idx = 4'd14; skey = exp_rk[14];
        if (keys_ready !== 1'b0) begin
            errors++; $display("FAIL ready_early got %b want 0", keys_ready);
        end
        checks++;
        @(negedge clk);
        skey_valid = 1'b0;
        if (keys_ready !== 1'b1 || load_err !== 1'b0) begin
            errors++; $display("FAIL ready_rise got ready %b err %b want 1 0", keys_ready, load_err);
        end
        checks++;
        commit_model();
        issue_read(14, 1'b0);
        if (rd_valid !== 1'b1 || rd_key !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            errors++; $display("FAIL fips_rk14 got %b %h want 1 24fc79ccbf0979e9371ac23c6d68de36", rd_valid, rd_key);
        end
        checks++;
        issue_read(1, 1'b0);
        if (rd_valid !== 1'b1 || rd_key !== 128'h101112131415161718191a1b1c1d1e1f) begin
            errors++; $display("FAIL fips_rk1 got %b %h want 1 101112131415161718191a1b1c1d1e1f", rd_valid, rd_key);
        end
        checks++;
        last_key = 128'h101112131415161718191a1b1c1d1e1f;
    endtask

    task automatic test_decrypt();
        issue_read(0, 1'b1);
        if (rd_valid !== 1'b1 || rd_key !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            errors++; $display("FAIL dec_r0 got %b %h want 1 24fc79ccbf0979e9371ac23c6d68de36", rd_valid, rd_key);
        end
        checks++;
        issue_read(14, 1'b1);
        if (rd_valid !== 1'b1 || rd_key !== 128'h000102030405060708090a0b0c0d0e0f) begin
            errors++; $display("FAIL dec_r14 got %b %h want 1 000102030405060708090a0b0c0d0e0f", rd_valid, rd_key);
        end
        checks++;
        last_key = 128'h000102030405060708090a0b0c0d0e0f;
    endtask

    // Issues a read every cycle; rd_round may exceed 14 when allow_bad is set, and rd_en may gap.
    task automatic stream_reads(input int n, input bit allow_bad, input string tag);
        logic         want_vld;
        logic [127:0] want_key;
        want_vld = 1'b0;
        want_key = last_key;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                if (rd_valid !== want_vld || rd_key !== want_key) begin
                    errors++;
                    $display("FAIL %s[%0d] got %b %h want %b %h", tag, k, rd_valid, rd_key, want_vld, want_key);
                end
                checks++;
            end
            if (k < n) begin
                int  r;
                bit  dec;
                bit  en;
                r   = allow_bad ? $urandom_range(15, 0) : $urandom_range(14, 0);
                dec = 1'($urandom);
                en  = allow_bad ? 1'($urandom) : 1'b1;
                rd_en = en; rd_round = 4'(r); rd_dec = dec;
                want_vld = en && (r <= 14);
                if (want_vld) want_key = model_rk[phys(r, dec)];
                @(negedge clk);
            end
        end
        rd_en = 1'b0;
        last_key = want_key;
    endtask

    task automatic test_back_to_back();
        stream_reads(16, 1'b0, "b2b");
    endtask

    task automatic test_random_reads();
        stream_reads(40, 1'b1, "rand_rd");
    endtask

    task automatic test_protocol_error();
        start_load(rand_key());
        feed(1, 2, 0);
        skey_valid = 1'b1; skey_idx = 4'd4; skey = exp_rk[4];
        @(negedge clk);
        skey_valid = 1'b0;
        if (load_err !== 1'b1 || keys_ready !== 1'b0) begin
            errors++; $display("FAIL proto_err got err %b ready %b want 1 0", load_err, keys_ready);
        end
        checks++;
        issue_read(3, 1'b0);
        if (rd_valid !== 1'b0 || rd_key !== last_key) begin
            errors++; $display("FAIL proto_read got %b %h want 0 %h", rd_valid, rd_key, last_key);
        end
        checks++;
        start_load(rand_key());
        if (load_err !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b want 0", load_err);
        end
        checks++;
        feed(1, 14, 0);
        commit_model();
    endtask

    task automatic test_stall();
        start_load(rand_key());
        feed(1, 14, 3);
        if (keys_ready !== 1'b1 || load_err !== 1'b0) begin
            errors++; $display("FAIL stall_ready got ready %b err %b want 1 0", keys_ready, load_err);
        end
        checks++;
        commit_model();
        for (int r = 0; r < 15; r++) begin
            issue_read(r, 1'b0);
            if (rd_valid !== 1'b1 || rd_key !== model_rk[r]) begin
                errors++; $display("FAIL stall_rk%0d got %b %h want 1 %h", r, rd_valid, rd_key, model_rk[r]);
            end
            checks++;
            last_key = model_rk[r];
        end
    endtask

    task automatic test_reload();
        expand_key(rand_key());
        load_start = 1'b1; rk0_in = exp_rk[0];
        rd_en = 1'b1; rd_round = 4'd5; rd_dec = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        if (rd_valid !== 1'b1 || rd_key !== model_rk[5] || keys_ready !== 1'b0) begin
            errors++; $display("FAIL reload_old got %b %h ready %b want 1 %h 0", rd_valid, rd_key, keys_ready, model_rk[5]);
        end
        checks++;
        last_key = model_rk[5];
        @(negedge clk);
        rd_en = 1'b0;
        if (rd_valid !== 1'b0 || rd_key !== last_key) begin
            errors++; $display("FAIL reload_reject got %b %h want 0 %h", rd_valid, rd_key, last_key);
        end
        checks++;
        feed(1, 14, 0);
        commit_model();
        issue_read(5, 1'b0);
        if (rd_valid !== 1'b1 || rd_key !== model_rk[5]) begin
            errors++; $display("FAIL reload_new got %b %h want 1 %h", rd_valid, rd_key, model_rk[5]);
        end
        checks++;
        // Round-0 read in the load cycle must see the incoming key.
        expand_key(rand_key());
        load_start = 1'b1; rk0_in = exp_rk[0];
        rd_en = 1'b1; rd_round = 4'd14; rd_dec = 1'b1;
        @(negedge clk);
        load_start = 1'b0; rd_en = 1'b0;
        if (rd_valid !== 1'b1 || rd_key !== exp_rk[0]) begin
            errors++; $display("FAIL reload_rk0 got %b %h want 1 %h", rd_valid, rd_key, exp_rk[0]);
        end
        checks++;
        last_key = exp_rk[0];
        feed(1, 14, 0);
        commit_model();
    endtask

    task automatic test_reset_mid_load();
        start_load(rand_key());
        feed(1, 7, 0);
        reset_n = 1'b0;
        #1;
        if ({rd_valid, keys_ready, load_err} !== 3'b000 || rd_key !== 128'h0) begin
            errors++; $display("FAIL midload_reset got %b %h want 000 0", {rd_valid, keys_ready, load_err}, rd_key);
        end
        checks++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue_read(2, 1'b0);
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_read got %b want 0", rd_valid);
        end
        checks++;
        skey_valid = 1'b1; skey_idx = 4'd9; skey = exp_rk[9];
        @(negedge clk);
        skey_valid = 1'b0;
        @(negedge clk);
        if (load_err !== 1'b0 || keys_ready !== 1'b0) begin
            errors++; $display("FAIL post_reset_skey got err %b ready %b want 0 0", load_err, keys_ready);
        end
        checks++;
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_normal_load();
        test_decrypt();
        test_back_to_back();
        test_random_reads();
        test_protocol_error();
        test_stall();
        test_reload();
        test_random_reads();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
